// File: rtl/icache_pkg.sv
// Shared geometry, address-field positions and FSM encoding for the instruction cache.
// Pure definitions: no logic, no latency and no flow control of its own.
package icache_pkg;

  localparam int ADDR_W      = 10;
  localparam int NUM_BLOCKS  = 8;
  localparam int BLOCK_WORDS = 4;
  localparam int WORD_W      = 32;
  localparam int BLK_W       = BLOCK_WORDS * WORD_W;
  localparam int IDX_W       = $clog2(NUM_BLOCKS);
  localparam int WSEL_W      = $clog2(BLOCK_WORDS);
  localparam int OFF_W       = WSEL_W + 2;
  localparam int TAG_W       = ADDR_W - IDX_W - OFF_W;
  localparam int MADDR_W     = TAG_W + IDX_W;

  localparam int WORD_LSB = 2;
  localparam int IDX_LSB  = OFF_W;
  localparam int TAG_LSB  = OFF_W + IDX_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
  } blk_addr_t;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: combinational read of one word, one synchronous whole-line fill.
// Fill and valid clear land on the rising edge; no backpressure, clear wins over fill.
module icache_line_store
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               i_clr_valid,
  input  logic [IDX_W-1:0]   i_rd_idx,
  input  logic [WSEL_W-1:0]  i_rd_word,
  output logic               o_rd_valid,
  output logic [TAG_W-1:0]   o_rd_tag,
  output logic [WORD_W-1:0]  o_rd_word,
  input  logic               i_fill_en,
  input  logic [IDX_W-1:0]   i_fill_idx,
  input  logic [TAG_W-1:0]   i_fill_tag,
  input  logic [BLK_W-1:0]   i_fill_data
);

  logic [NUM_BLOCKS-1:0]                r_valid;
  logic [TAG_W-1:0]                     r_tag  [NUM_BLOCKS];
  logic [BLOCK_WORDS-1:0][WORD_W-1:0]   r_data [NUM_BLOCKS];
  logic [BLOCK_WORDS-1:0][WORD_W-1:0]   w_line;

  always_ff @(posedge clk) begin
    if (i_clr_valid) begin
      r_valid <= '0;
    end else if (i_fill_en) begin
      r_valid[i_fill_idx] <= 1'b1;
    end
  end

  // Tag and data keep their contents across reset; only the valid bits matter.
  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_tag[i_fill_idx]  <= i_fill_tag;
      r_data[i_fill_idx] <= i_fill_data;
    end
  end

  assign w_line     = r_data[i_rd_idx];
  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_word  = w_line[i_rd_word];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: hits return the word combinationally (0 cycles),
// misses hold BUSYWAIT for 3+k cycles while one 128-bit line is fetched over READ/BUSYWAIT.
module icache
  import icache_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic [ADDR_W-1:0]   ADDRESS,
  input  logic                READ,
  output logic [WORD_W-1:0]   INSTRUCTION,
  output logic                BUSYWAIT,
  output logic                MEM_READ,
  output logic [MADDR_W-1:0]  MEM_ADDRESS,
  input  logic [BLK_W-1:0]    MEM_READDATA,
  input  logic                MEM_BUSYWAIT
);

  state_t              r_state;
  blk_addr_t           r_miss_addr;
  logic                r_mem_read;

  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_idx;
  logic [WSEL_W-1:0]   w_word;
  logic                w_line_valid;
  logic [TAG_W-1:0]    w_line_tag;
  logic                w_hit;
  logic                w_fill;

  assign w_tag  = ADDRESS[TAG_LSB +: TAG_W];
  assign w_idx  = ADDRESS[IDX_LSB +: IDX_W];
  assign w_word = ADDRESS[WORD_LSB +: WSEL_W];

  icache_line_store u_store (
    .clk         (CLK),
    .i_clr_valid (RESET),
    .i_rd_idx    (w_idx),
    .i_rd_word   (w_word),
    .o_rd_valid  (w_line_valid),
    .o_rd_tag    (w_line_tag),
    .o_rd_word   (INSTRUCTION),
    .i_fill_en   (w_fill),
    .i_fill_idx  (r_miss_addr.idx),
    .i_fill_tag  (r_miss_addr.tag),
    .i_fill_data (MEM_READDATA)
  );

  assign w_hit  = READ & w_line_valid & (w_line_tag == w_tag) & (r_state == S_IDLE);
  // A reset landing on the completing edge must not leave a half-finished line behind.
  assign w_fill = (r_state == S_MEM_READ) & ~MEM_BUSYWAIT & ~RESET;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_mem_read <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_mem_read <= 1'b0;
          if (READ && !w_hit) begin
            r_miss_addr <= '{tag: w_tag, idx: w_idx};
            r_state     <= S_MEM_READ;
            r_mem_read  <= 1'b1;
          end
        end
        S_MEM_READ: begin
          r_mem_read <= MEM_BUSYWAIT;
          if (!MEM_BUSYWAIT) begin
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_mem_read <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_mem_read <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  // The fetch address is frozen in r_miss_addr, so PC wiggles during a miss are harmless.
  assign MEM_ADDRESS = r_miss_addr;
  assign MEM_READ    = r_mem_read & ~RESET;
  assign BUSYWAIT    = ~RESET & ((r_state != S_IDLE) | (READ & ~w_hit));

endmodule
